// File: rtl/enigma_pkg.sv
// Shared definitions for the rotor stepping engine: FSM states, default
// alphabet size and the historical Enigma notch positions.
package enigma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_STEP    = 2'd1,
        ST_PRESENT = 2'd2
    } step_state_e;

    localparam int ALPHA_DEFAULT = 26;

    // Turnover letters of the military rotors, as 0-based alphabet indices
    localparam int NOTCH_I   = 16;
    localparam int NOTCH_II  = 4;
    localparam int NOTCH_III = 21;
    localparam int NOTCH_IV  = 9;
    localparam int NOTCH_V   = 25;

endpackage

// File: rtl/rotor_step_logic.sv
// Combinational next-position calculation for one keypress, in either
// odometer-carry or notch (double-step) mode.
module rotor_step_logic
    import enigma_pkg::*;
#(
    parameter  int NUM_ROTORS = 3,
    parameter  int ALPHA      = ALPHA_DEFAULT,
    localparam int POS_W      = $clog2(ALPHA)
) (
    input  logic [NUM_ROTORS*POS_W-1:0] i_pos,
    input  logic [NUM_ROTORS*POS_W-1:0] i_notch,
    input  logic                        i_mode,
    output logic [NUM_ROTORS*POS_W-1:0] o_next_pos,
    output logic                        o_wrap
);

    logic [NUM_ROTORS-1:0] w_at_max;
    logic [NUM_ROTORS-1:0] w_at_notch;
    logic [NUM_ROTORS-1:0] w_carry;
    logic [NUM_ROTORS-1:0] w_notch_step;
    logic [NUM_ROTORS-1:0] w_step;

    for (genvar i = 0; i < NUM_ROTORS; i++) begin : g_rotor
        logic [POS_W-1:0] w_p;
        logic [POS_W-1:0] w_n;

        assign w_p           = i_pos[i*POS_W +: POS_W];
        assign w_n           = i_notch[i*POS_W +: POS_W];
        assign w_at_max[i]   = (w_p == POS_W'(ALPHA - 1));
        assign w_at_notch[i] = (w_p == w_n);

        // Rotor 0 always moves; the last rotor only follows its neighbour,
        // middle rotors also drag themselves along when sitting on their notch.
        if (i == 0) begin : g_first
            assign w_carry[i]      = 1'b1;
            assign w_notch_step[i] = 1'b1;
        end else if (i == NUM_ROTORS - 1) begin : g_last
            assign w_carry[i]      = &w_at_max[i-1:0];
            assign w_notch_step[i] = w_at_notch[i-1];
        end else begin : g_mid
            assign w_carry[i]      = &w_at_max[i-1:0];
            assign w_notch_step[i] = w_at_notch[i-1] | w_at_notch[i];
        end

        assign w_step[i] = i_mode ? w_notch_step[i] : w_carry[i];
        assign o_next_pos[i*POS_W +: POS_W] =
            !w_step[i]  ? w_p :
            w_at_max[i] ? '0  : w_p + POS_W'(1);
    end

    assign o_wrap = ~i_mode & (&w_at_max);

endmodule

// File: rtl/rotor_step_engine.sv
// Rotor position engine: keypress handshake, preset loading and a
// three-state IDLE/STEP/PRESENT sequencer around rotor_step_logic.
module rotor_step_engine
    import enigma_pkg::*;
#(
    parameter  int NUM_ROTORS = 3,
    parameter  int ALPHA      = ALPHA_DEFAULT,
    localparam int POS_W      = $clog2(ALPHA)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        key_valid,
    output logic                        key_ready,
    input  logic                        load,
    input  logic [NUM_ROTORS*POS_W-1:0] load_pos,
    input  logic [NUM_ROTORS*POS_W-1:0] load_notch,
    input  logic                        mode,
    output logic [NUM_ROTORS*POS_W-1:0] pos_out,
    output logic                        pos_valid,
    output logic                        wrap,
    output logic                        load_err
);

    localparam int PW = NUM_ROTORS * POS_W;

    step_state_e r_state;
    step_state_e w_state_next;

    logic [PW-1:0] r_pos;
    logic [PW-1:0] r_notch;
    logic          r_mode;
    logic          r_key_ready;
    logic          r_pos_valid;
    logic          r_wrap;
    logic          r_load_err;

    logic [PW-1:0] w_next_pos;
    logic [PW-1:0] w_load_pos;
    logic [PW-1:0] w_load_notch;
    logic          w_load_bad;
    logic          w_step_wrap;
    logic          w_load_take;
    logic          w_accept;

    assign w_load_take = load & (r_state == ST_IDLE);
    // key_ready is only ever high in IDLE, so this also implies IDLE
    assign w_accept    = key_valid & r_key_ready & ~load;

    rotor_step_logic #(
        .NUM_ROTORS (NUM_ROTORS),
        .ALPHA      (ALPHA)
    ) u_step_logic (
        .i_pos      (r_pos),
        .i_notch    (r_notch),
        .i_mode     (r_mode),
        .o_next_pos (w_next_pos),
        .o_wrap     (w_step_wrap)
    );

    // Out-of-alphabet preset fields are replaced by 0 and flagged
    always_comb begin
        w_load_pos   = '0;
        w_load_notch = '0;
        w_load_bad   = 1'b0;
        for (int i = 0; i < NUM_ROTORS; i++) begin
            if (32'(load_pos[i*POS_W +: POS_W]) < ALPHA) begin
                w_load_pos[i*POS_W +: POS_W] = load_pos[i*POS_W +: POS_W];
            end else begin
                w_load_bad = 1'b1;
            end
            if (32'(load_notch[i*POS_W +: POS_W]) < ALPHA) begin
                w_load_notch[i*POS_W +: POS_W] = load_notch[i*POS_W +: POS_W];
            end else begin
                w_load_bad = 1'b1;
            end
        end
    end

    // Next-state decode
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = ST_STEP;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_STEP:    w_state_next = ST_PRESENT;
            ST_PRESENT: w_state_next = ST_IDLE;
            default:    w_state_next = ST_IDLE;
        endcase
    end

    // State register and registered handshake/status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_key_ready <= 1'b0;
            r_pos_valid <= 1'b0;
            r_wrap      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_key_ready <= (w_state_next == ST_IDLE);
            r_pos_valid <= (w_state_next == ST_PRESENT);
            r_wrap      <= (r_state == ST_STEP) & w_step_wrap;
        end
    end

    // Rotor positions, notches, per-step mode and sticky load error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pos      <= '0;
            r_notch    <= '0;
            r_mode     <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            if (w_load_take) begin
                r_pos   <= w_load_pos;
                r_notch <= w_load_notch;
            end else if (r_state == ST_STEP) begin
                r_pos   <= w_next_pos;
            end
            if (w_accept) begin
                r_mode <= mode;
            end
            if (w_load_take && w_load_bad) begin
                r_load_err <= 1'b1;
            end
        end
    end

    assign key_ready = r_key_ready;
    assign pos_out   = r_pos;
    assign pos_valid = r_pos_valid;
    assign wrap      = r_wrap;
    assign load_err  = r_load_err;

endmodule

// File: doc/rotor_step_engine.md
Name: rotor_step_engine

Overview:
- Parametrised successor to the team's rotor-position engine: keeps an array of NUM_ROTORS rotor positions (mod ALPHA) and advances them once per accepted keypress.
- Supports two stepping modes: plain odometer carry, and historical Enigma notch stepping with the double-step anomaly.
- Adds synchronous operation, a valid/ready keypress handshake, preset loading of start positions and notches, and wrap/error reporting.
- Sits between the keyboard decoder and the rotor/reflector substitution path, which consumes pos_out.

Parameters:
- NUM_ROTORS, 3, number of rotors; index 0 is the fastest (rightmost) rotor; legal range ≥2.
- ALPHA, 26, alphabet size; positions run 0..ALPHA-1.
- POS_W, $clog2(ALPHA), localparam; width of one position field.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- key_valid  input  1  keypress request.
- key_ready  output  1  engine can accept a keypress.
- load  input  1  single-cycle preset strobe.
- load_pos  input  NUM_ROTORS*POS_W  start positions; rotor i is in bits [i*POS_W +: POS_W].
- load_notch  input  NUM_ROTORS*POS_W  notch positions, packed the same way.
- mode  input  1  stepping mode: 0 = odometer, 1 = notch/double-step.
- pos_out  output  NUM_ROTORS*POS_W  current rotor positions, registered.
- pos_valid  output  1  one-cycle pulse when pos_out reflects a completed step.
- wrap  output  1  one-cycle pulse with pos_valid; odometer mode only; all rotors rolled over to 0.
- load_err  output  1  sticky flag; a loaded field was ≥ ALPHA.

Behaviour:
- Reset (asynchronous, rst=1):
  - all positions and notches = 0;
  - FSM = IDLE;
  - key_ready = 0 while rst is high, then 1 in IDLE;
  - pos_valid = 0, wrap = 0, load_err = 0.
- FSM states:
  - IDLE: key_ready=1.
  - STEP: key_ready=0; new positions are registered here.
  - PRESENT: key_ready=0; pos_valid=1 for this cycle only; next state IDLE.
- Transitions:
  - IDLE→STEP on key_valid && key_ready && !load.
  - STEP→PRESENT unconditionally.
  - PRESENT→IDLE unconditionally.
  - Throughput: one keypress per 3 cycles.
  - Latency: handshake edge to pos_valid high = 2 cycles.
- mode is sampled at the handshake edge and held for that step. Changing mode mid-step has no effect.
- Load (honoured in IDLE only; ignored in STEP and PRESENT):
  - positions and notches are latched from load_pos/load_notch;
  - load wins over key_valid in the same cycle, and that keypress is not accepted;
  - any field ≥ ALPHA is stored as 0 and sets load_err;
  - load_err clears only on reset.
- Step rules, all evaluated on pre-step values p[i], notch n[i]; wrap-around is ALPHA-1 → 0.
  - Odometer mode:
    - rotor 0 always increments;
    - rotor i≥1 increments iff every rotor j<i was at ALPHA-1;
    - wrap=1 iff every rotor was at ALPHA-1.
  - Notch mode:
    - rotor 0 always steps;
    - rotor i≥1 steps if p[i-1]==n[i-1];
    - rotor i with 1≤i≤NUM_ROTORS-2 also steps if p[i]==n[i] (double step);
    - the last rotor never double-steps;
    - a rotor steps at most one position per keypress;
    - wrap is always 0.
- No output changes in IDLE except after load. pos_out updates on the STEP→PRESENT edge and is stable otherwise.
- Reset mid-step aborts the step; no pos_valid is issued.

Decomposition:
- Shared package enigma_pkg holds:
  - the FSM state enum;
  - the default ALPHA = 26;
  - historical notch constants (rotor I=16 'Q', II=4 'E', III=21 'V', IV=9 'J', V=25 'Z').
- One sub-module, rotor_step_logic: purely combinational.
  - Inputs: positions, notches, mode.
  - Outputs: next positions and the wrap flag.
  - Built with a generate loop over NUM_ROTORS.
- The top level holds the FSM, registers and handshake.

Test Plan:
- Reset check: assert rst mid-PRESENT → pos_out=0, pos_valid=0, key_ready=1 one cycle after deassert.
- Odometer carry: mode=0, load pos (r2,r1,r0)=(0,0,25), one keypress → (0,1,0); pos_valid pulses exactly 2 cycles after the handshake.
- Odometer full wrap: mode=0, load (25,25,25), keypress → (0,0,0) with wrap=1 for one cycle.
- Double step: mode=1, notches (r2,r1,r0)=(16,4,21), load (0,3,20), three keypresses → (0,3,21), (0,4,22), (1,5,23), i.e. ADU→ADV→AEW→BFX.
- Load collisions:
  - load and key_valid in the same IDLE cycle → load applied, no step, no pos_valid;
  - load_pos field 30 → stored 0, load_err=1 until reset.
- Back-pressure: hold key_valid high for 9 cycles → exactly 3 accepted steps; key_ready low in STEP and PRESENT.
